// File: rtl/lif_sched_pkg.sv
// Shared constants, FSM encoding and width helper for the LIF sweep scheduler.
// Default neuron count, firing threshold, leak and refractory values live here.
package lif_sched_pkg;

    localparam int DEF_N_NEURONS  = 4;
    localparam int DEF_THRESHOLD  = 200;
    localparam int DEF_LEAK_SHIFT = 1;
    localparam int DEF_REFRACT    = 2;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int REFR_W         = 4;

    // Index width for n entries; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_ID_W = id_width(DEF_N_NEURONS);

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } sched_state_t;

endpackage

// File: rtl/lif_update.sv
// Combinational leaky integrate-and-fire step for one virtual neuron.
// A refractory neuron is held at zero; otherwise leak, integrate and compare.
module lif_update
    import lif_sched_pkg::*;
#(
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int REFRACT    = DEF_REFRACT
) (
    input  logic [7:0]        state_in,
    input  logic [REFR_W-1:0] refr_in,
    input  logic [7:0]        cur_in,
    output logic [7:0]        state_out,
    output logic [REFR_W-1:0] refr_out,
    output logic              spike
);

    localparam logic [8:0]        THR       = 9'(THRESHOLD);
    localparam logic [REFR_W-1:0] REFR_INIT = REFR_W'(REFRACT);

    logic [7:0] leaked;
    logic [8:0] sum;

    always_comb begin
        leaked    = state_in - (state_in >> LEAK_SHIFT);
        sum       = {1'b0, leaked} + {1'b0, cur_in};
        state_out = sum[7:0];
        refr_out  = '0;
        spike     = 1'b0;
        if (refr_in != '0) begin
            state_out = '0;
            refr_out  = refr_in - REFR_W'(1);
        end else if (sum >= THR) begin
            spike     = 1'b1;
            state_out = '0;
            refr_out  = REFR_INIT;
        end
    end

endmodule

// File: rtl/lif_sweep_scheduler.sv
// Time-multiplexed LIF neuron array: each accepted tick sweeps every neuron once,
// one per cycle, and queues spiking neuron IDs in an event FIFO.
module lif_sweep_scheduler
    import lif_sched_pkg::*;
#(
    parameter int N_NEURONS  = DEF_N_NEURONS,
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int REFRACT    = DEF_REFRACT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int ID_W      = id_width(N_NEURONS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            tick,
    input  logic            cfg_we,
    input  logic [ID_W-1:0] cfg_addr,
    input  logic [7:0]      cfg_data,
    input  logic [ID_W-1:0] obs_sel,
    output logic [7:0]      obs_state,
    output logic            spike_valid,
    input  logic            spike_ready,
    output logic [ID_W-1:0] spike_id,
    output logic            busy,
    output logic            sweep_done,
    output logic            overflow,
    output logic            tick_miss
);

    localparam int PTR_W = id_width(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    sched_state_t    fsm_reg, fsm_next;
    logic [ID_W-1:0] idx_reg, idx_next;
    logic            last_next;
    logic            sweep_done_reg, overflow_reg, tick_miss_reg;

    logic [7:0]        v_reg    [N_NEURONS];
    logic [REFR_W-1:0] refr_reg [N_NEURONS];
    logic [7:0]        cur_reg  [N_NEURONS];

    logic [ID_W-1:0]  fifo_reg [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic [7:0]        upd_state;
    logic [REFR_W-1:0] upd_refr;
    logic              upd_spike;
    logic              push, pop, full, do_push;

    lif_update #(
        .THRESHOLD (THRESHOLD),
        .LEAK_SHIFT(LEAK_SHIFT),
        .REFRACT   (REFRACT)
    ) u_update (
        .state_in (v_reg[idx_reg]),
        .refr_in  (refr_reg[idx_reg]),
        .cur_in   (cur_reg[idx_reg]),
        .state_out(upd_state),
        .refr_out (upd_refr),
        .spike    (upd_spike)
    );

    always_comb begin
        fsm_next  = fsm_reg;
        idx_next  = idx_reg;
        last_next = 1'b0;
        case (fsm_reg)
            ST_IDLE: begin
                if (tick && ena) begin
                    fsm_next = ST_SWEEP;
                    idx_next = '0;
                end
            end
            ST_SWEEP: begin
                idx_next = idx_reg + ID_W'(1);
                if (idx_reg == ID_W'(N_NEURONS - 1)) begin
                    fsm_next  = ST_IDLE;
                    idx_next  = '0;
                    last_next = 1'b1;
                end
            end
            default: fsm_next = ST_IDLE;
        endcase
    end

    assign busy        = (fsm_reg == ST_SWEEP);
    assign spike_valid = (count_reg != '0);
    assign full        = (count_reg == CNT_W'(FIFO_DEPTH));
    assign push        = busy && upd_spike;
    assign pop         = spike_valid && spike_ready;
    // A full FIFO still accepts an event when the head leaves in the same cycle.
    assign do_push     = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg        <= ST_IDLE;
            idx_reg        <= '0;
            sweep_done_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            tick_miss_reg  <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
        end else begin
            fsm_reg        <= fsm_next;
            idx_reg        <= idx_next;
            sweep_done_reg <= last_next;
            if (push && full && !pop)
                overflow_reg <= 1'b1;
            if (tick && ena && busy)
                tick_miss_reg <= 1'b1;
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (do_push && !pop)
                count_reg <= count_reg + CNT_W'(1);
            else if (!do_push && pop)
                count_reg <= count_reg - CNT_W'(1);
        end
    end

    for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_reg[gi]    <= '0;
                refr_reg[gi] <= '0;
                cur_reg[gi]  <= '0;
            end else begin
                if (busy && idx_reg == ID_W'(gi)) begin
                    v_reg[gi]    <= upd_state;
                    refr_reg[gi] <= upd_refr;
                end
                if (cfg_we && cfg_addr == ID_W'(gi))
                    cur_reg[gi] <= cfg_data;
            end
        end
    end

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                fifo_reg[gi] <= '0;
            else if (do_push && wr_ptr_reg == PTR_W'(gi))
                fifo_reg[gi] <= idx_reg;
        end
    end

    assign obs_state  = v_reg[obs_sel];
    assign spike_id   = fifo_reg[rd_ptr_reg];
    assign sweep_done = sweep_done_reg;
    assign overflow   = overflow_reg;
    assign tick_miss  = tick_miss_reg;

endmodule

// File: tb/tb_lif_sweep_scheduler.sv
// Scoreboard bench for lif_sweep_scheduler: stimulus queues expected spike IDs,
// a negedge monitor compares every FIFO pop against the queue head.
module tb_lif_sweep_scheduler;
    import lif_sched_pkg::*;

    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ena = 1'b0;
    logic           tick = 1'b0;
    logic           cfg_we = 1'b0;
    logic [IDW-1:0] cfg_addr = '0;
    logic [7:0]     cfg_data = '0;
    logic [IDW-1:0] obs_sel = '0;
    logic           spike_ready = 1'b0;
    logic [7:0]     obs_state;
    logic           spike_valid;
    logic [IDW-1:0] spike_id;
    logic           busy, sweep_done, overflow, tick_miss;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int busy_cnt = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    lif_sweep_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .tick       (tick),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .obs_sel    (obs_sel),
        .obs_state  (obs_state),
        .spike_valid(spike_valid),
        .spike_ready(spike_ready),
        .spike_id   (spike_id),
        .busy       (busy),
        .sweep_done (sweep_done),
        .overflow   (overflow),
        .tick_miss  (tick_miss)
    );

    // Monitor: a handshake seen at negedge completes on the following posedge.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (sweep_done) done_cnt++;
        if (spike_valid && spike_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spike_unexpected: got id %0d, required no event", spike_id);
            end else begin
                automatic int e = exp_q.pop_front();
                $display("pop spike_id=%0d expected=%0d", spike_id, e);
                if (int'(spike_id) != e) begin
                    errors++;
                    $display("FAIL spike_id: got %0d, required %0d", spike_id, e);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_addr = IDW'(addr);
        cfg_data = 8'(data);
        step(1);
        cfg_we   = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1);
            if (sweep_done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL sweep_timeout: got no sweep_done, required one within 20 cycles");
        end
    endtask

    task automatic run_sweep();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        wait_done();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        tick        = 1'b0;
        cfg_we      = 1'b0;
        spike_ready = 1'b0;
        ena         = 1'b1;
        step(2);
        exp_q.delete();
        busy_cnt = 0;
        done_cnt = 0;
        rst_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        int obs_exp[6] = '{150, 0, 0, 0, 150, 0};

        // Reset values while rst_n is held low
        #1;
        check("rst_busy", busy, 0);
        check("rst_spike_valid", spike_valid, 0);
        check("rst_sweep_done", sweep_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tick_miss", tick_miss, 0);
        check("rst_obs_state", obs_state, 0);

        // Single driven neuron: spikes only in sweeps 2 and 6
        do_reset();
        cfg_write(0, 150);
        spike_ready = 1'b1;
        for (int s = 1; s <= 6; s++) begin
            if (s == 2 || s == 6) exp_q.push_back(0);
            run_sweep();
            step(2);
            $display("sweep %0d obs_state0=%0d", s, obs_state);
            check($sformatf("obs_state0_sweep%0d", s), obs_state, obs_exp[s-1]);
        end
        check("drained_after_leak_test", exp_q.size(), 0);

        // All neurons saturated with no consumer: fill, refractory, overflow
        do_reset();
        for (int i = 0; i < 4; i++) cfg_write(i, 255);
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        run_sweep();
        run_sweep();
        run_sweep();
        check("ovf_before_sweep4", overflow, 0);
        check("valid_while_full", spike_valid, 1);
        run_sweep();
        check("ovf_after_sweep4", overflow, 1);
        spike_ready = 1'b1;
        step(6);
        spike_ready = 1'b0;
        check("valid_after_drain", spike_valid, 0);
        check("ovf_sticky", overflow, 1);
        check("drained_after_ovf_test", exp_q.size(), 0);

        // Disabled tick is ignored silently; tick during sweep is flagged
        do_reset();
        ena  = 1'b0;
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(2);
        check("ena_off_busy_cycles", busy_cnt, 0);
        check("ena_off_tick_miss", tick_miss, 0);
        ena  = 1'b1;
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(1);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        wait_done();
        step(3);
        check("busy_cycles", busy_cnt, 4);
        check("sweep_done_pulses", done_cnt, 1);
        check("tick_miss", tick_miss, 1);
        check("busy_after_sweep", busy, 0);

        // Current written during neuron 2's own update takes effect next sweep
        do_reset();
        obs_sel     = IDW'(2);
        spike_ready = 1'b1;
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(2);
        cfg_we   = 1'b1;
        cfg_addr = IDW'(2);
        cfg_data = 8'd250;
        step(1);
        cfg_we   = 1'b0;
        wait_done();
        step(1);
        check("n2_state_after_cfg_sweep", obs_state, 0);
        exp_q.push_back(2);
        run_sweep();
        step(2);
        check("n2_state_after_spike", obs_state, 0);
        check("drained_after_cfg_test", exp_q.size(), 0);
        obs_sel = '0;

        // Asynchronous reset mid-sweep with queued events
        do_reset();
        for (int i = 0; i < 4; i++) cfg_write(i, 255);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(3);
        check("valid_before_async_rst", spike_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", spike_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_sweep_done", sweep_done, 0);
        check("async_rst_overflow", overflow, 0);
        check("async_rst_obs_state", obs_state, 0);
        step(1);
        busy_cnt = 0;
        done_cnt = 0;
        rst_n    = 1'b1;
        run_sweep();
        check("post_rst_busy_cycles", busy_cnt, 4);
        check("post_rst_valid", spike_valid, 0);
        spike_ready = 1'b1;
        cfg_write(0, 255);
        exp_q.push_back(0);
        run_sweep();
        step(2);
        check("drained_after_rst_test", exp_q.size(), 0);

        // Full FIFO with simultaneous push and pop on every update cycle
        do_reset();
        for (int i = 0; i < 4; i++) cfg_write(i, 255);
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        run_sweep();
        run_sweep();
        run_sweep();
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        tick = 1'b1;
        step(1);
        tick        = 1'b0;
        spike_ready = 1'b1;
        wait_done();
        spike_ready = 1'b0;
        check("pushpop_overflow", overflow, 0);
        check("pushpop_valid", spike_valid, 1);
        check("pushpop_pending", exp_q.size(), 4);
        spike_ready = 1'b1;
        step(6);
        spike_ready = 1'b0;
        check("pushpop_drained_valid", spike_valid, 0);
        check("drained_after_pushpop_test", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
